// File: rtl/fixed_point_sqrt_seq_pkg.sv
// Shared fixed-point definitions for the Q8.4 datapath and the sequential square-root unit.
package fxp_pkg;

  localparam int unsigned FXP_WIDTH = 12;
  localparam int unsigned FXP_FRAC  = 4;

  // One root bit is produced per iteration; the radicand carries FXP_FRAC extra zero bits.
  function automatic int unsigned sqrt_iter(input int unsigned width);
    return (width + FXP_FRAC) / 2;
  endfunction

  localparam int unsigned FXP_ITER  = sqrt_iter(FXP_WIDTH);
  localparam int unsigned FXP_RAD_W = FXP_WIDTH + FXP_FRAC;
  // The remainder never exceeds 2*root, so ITER+1 bits plus two shifted-in bits suffice.
  localparam int unsigned FXP_REM_W = FXP_ITER + 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } sqrt_state_e;

endpackage

// File: rtl/fixed_point_sqrt_seq_if.sv
// Operand and result valid/ready handshakes of the square-root unit.
interface fixed_point_sqrt_seq_if #(
  parameter int unsigned WIDTH = fxp_pkg::FXP_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_root;
  logic             out_err;

  // Producer/consumer side.
  modport master (
    output in_valid, in_a, out_ready,
    input  in_ready, out_valid, out_root, out_err
  );

  // Square-root unit side.
  modport slave (
    input  in_valid, in_a, out_ready,
    output in_ready, out_valid, out_root, out_err
  );

endinterface

// File: rtl/fixed_point_sqrt_seq_step.sv
// One restoring square-root iteration: shift in two radicand bits, try subtracting (root<<2)|1.
module fxsqrt_step #(
  parameter int unsigned ITER  = 8,
  parameter int unsigned REM_W = ITER + 3
) (
  input  logic [REM_W-1:0] rem,
  input  logic [ITER-1:0]  root,
  input  logic [1:0]       rad_bits,
  output logic [REM_W-1:0] rem_next,
  output logic [ITER-1:0]  root_next
);

  localparam int unsigned EXT_W = REM_W + 2;

  logic [EXT_W-1:0] rem_shift;
  logic [EXT_W-1:0] trial;
  logic [EXT_W-1:0] diff;
  logic             unused_hi;

  // Trial subtraction; the bits dropped from rem_shift/diff are provably zero for in-range roots.
  always_comb begin
    rem_shift = {rem, rad_bits};
    trial     = {{(EXT_W - ITER - 2){1'b0}}, root, 2'b01};
    diff      = rem_shift - trial;
    if (rem_shift >= trial) begin
      rem_next  = diff[REM_W-1:0];
      root_next = {root[ITER-2:0], 1'b1};
    end else begin
      rem_next  = rem_shift[REM_W-1:0];
      root_next = {root[ITER-2:0], 1'b0};
    end
  end

  assign unused_hi = ^{diff[EXT_W-1:REM_W], rem_shift[EXT_W-1:REM_W], root[ITER-1]};

endmodule

// File: rtl/fixed_point_sqrt_seq.sv
// Sequential Q8.4 square root, one result bit per clock, fixed 8-cycle latency.
// Optional build macro FXSQRT_ROUND_EN: round the root to nearest instead of truncating.
module fixed_point_sqrt_seq
  import fxp_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  fixed_point_sqrt_seq_if.slave bus
);

  localparam int unsigned WIDTH = FXP_WIDTH;
  localparam int unsigned ITER  = FXP_ITER;
  localparam int unsigned RAD_W = FXP_RAD_W;
  localparam int unsigned REM_W = FXP_REM_W;
  localparam int unsigned CNT_W = $clog2(ITER);

  sqrt_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RAD_W-1:0] rad_q, rad_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [ITER-1:0]  root_q, root_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] out_root_q, out_root_d;
  logic             out_err_q, out_err_d;

  logic [REM_W-1:0] step_rem;
  logic [ITER-1:0]  step_root;
  logic [ITER-1:0]  root_fin;

  fxsqrt_step #(
    .ITER  (ITER),
    .REM_W (REM_W)
  ) u_step (
    .rem       (rem_q),
    .root      (root_q),
    .rad_bits  (rad_q[RAD_W-1 -: 2]),
    .rem_next  (step_rem),
    .root_next (step_root)
  );

  // Final root after the last step, optionally rounded to nearest (cannot overflow ITER bits).
  always_comb begin
    root_fin = step_root;
`ifdef FXSQRT_ROUND_EN
    if (step_rem > {{(REM_W - ITER){1'b0}}, step_root}) begin
      root_fin = step_root + ITER'(1);
    end
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    err_d      = err_q;
    out_root_d = out_root_q;
    out_err_d  = out_err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CALC;
          cnt_d   = CNT_W'(ITER - 1);
          rad_d   = {bus.in_a, {FXP_FRAC{1'b0}}};
          rem_d   = '0;
          root_d  = '0;
          err_d   = bus.in_a[WIDTH-1];
        end
      end
      CALC: begin
        rem_d  = step_rem;
        root_d = step_root;
        rad_d  = {rad_q[RAD_W-3:0], 2'b00};
        if (cnt_q == '0) begin
          state_d    = DONE;
          // Negative operands still run the full iteration count to keep latency fixed.
          out_root_d = err_q ? '0 : {{(WIDTH - ITER){1'b0}}, root_fin};
          out_err_d  = err_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      err_q      <= 1'b0;
      out_root_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      err_q      <= err_d;
      out_root_q <= out_root_d;
      out_err_q  <= out_err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_root  = out_root_q;
  assign bus.out_err   = out_err_q;

endmodule
